// File: rtl/uart_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_packer_if
// Description : Word stream (data/strobe/address, valid/ready) from the packer
//               FIFO to the AXI write master.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_word_packer_if #(
    parameter int ADDR_W = 32
) ();
    logic [31:0]       m_data;
    logic [3:0]        m_strb;
    logic [ADDR_W-1:0] m_addr;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data,
        output m_strb,
        output m_addr,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_strb,
        input  m_addr,
        input  m_valid,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_packer
// Description : Packs UART bytes little-endian into address-tagged 32-bit
//               words, flushes partial words on idle timeout, buffers in a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_packer #(
    parameter int                FIFO_DEPTH     = 4,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                TIMEOUT_CYCLES = 100_000
) (
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    input  wire logic [7:0]                      rx_data,
    input  wire logic                            rx_done,
    uart_word_packer_if.master                   m_if,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
    output logic                                 overflow,
    input  wire logic                            ovf_clr
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t              r_state;
    logic [1:0]          r_idx;
    logic [31:0]         r_asm;
    logic [3:0]          r_strb;
    logic [c_TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0]   r_next_addr;
    logic                r_overflow;

    logic [31:0]         r_mem_data [FIFO_DEPTH];
    logic [3:0]          r_mem_strb [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_mem_addr [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [31:0]         w_word;
    logic [3:0]          w_wstrb;
    logic                w_full_push;
    logic                w_tmo_push;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_accept;
    logic                w_drop;

    // Merge the incoming byte into the assembly word so a 4th byte pushes on its own edge
    always_comb begin
        w_word  = r_asm;
        w_wstrb = r_strb;
        if (rx_done) begin
            w_word[8*r_idx +: 8] = rx_data;
            w_wstrb[r_idx]       = 1'b1;
        end
    end

    assign w_full_push = rx_done && (r_idx == 2'd3);
    assign w_tmo_push  = (r_state == S_FILL) && !rx_done &&
                         (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_push      = w_full_push || w_tmo_push;
    assign w_pop       = (r_count != '0) && m_if.m_ready;
    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_accept    = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_asm   <= '0;
            r_strb  <= '0;
            r_tmo   <= '0;
        end else if (w_push) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_asm   <= '0;
            r_strb  <= '0;
            r_tmo   <= '0;
        end else if (rx_done) begin
            r_state <= S_FILL;
            r_idx   <= r_idx + 2'd1;
            r_asm   <= w_word;
            r_strb  <= w_wstrb;
            r_tmo   <= '0;
        end else if (r_state == S_FILL) begin
            r_tmo   <= r_tmo + c_TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_next_addr <= BASE_ADDR;
            r_overflow  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_strb[i] <= '0;
                r_mem_addr[i] <= '0;
            end
        end else begin
            // When full with a pop, wr_ptr equals rd_ptr: the departing head slot is reused
            if (w_accept) begin
                r_mem_data[r_wr_ptr] <= w_word;
                r_mem_strb[r_wr_ptr] <= w_wstrb;
                r_mem_addr[r_wr_ptr] <= r_next_addr;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
                r_next_addr          <= r_next_addr + ADDR_W'(4);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign m_if.m_data  = r_mem_data[r_rd_ptr];
    assign m_if.m_strb  = r_mem_strb[r_rd_ptr];
    assign m_if.m_addr  = r_mem_addr[r_rd_ptr];
    assign m_if.m_valid = (r_count != '0);
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_packer
// Description : Directed bench with a queue-based reference model for the
//               word packer, plus a narrow-address instance for wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_packer;
    localparam int c_DEPTH = 4;
    localparam int c_TMO   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       ovf_clr;

    logic [7:0] rx2_data;
    logic       rx2_done;
    logic [2:0] fifo_count2;
    logic       overflow2;
    logic       ovf_clr2;

    int n_cmp = 0;
    int n_bad = 0;

    uart_word_packer_if #(.ADDR_W(32)) mif ();
    uart_word_packer_if #(.ADDR_W(4))  mif2 ();

    uart_word_packer #(
        .FIFO_DEPTH(c_DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(c_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .m_if(mif), .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    uart_word_packer #(
        .FIFO_DEPTH(c_DEPTH), .ADDR_W(4), .BASE_ADDR(4'hC), .TIMEOUT_CYCLES(c_TMO)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx2_data), .rx_done(rx2_done),
        .m_if(mif2), .fifo_count(fifo_count2), .overflow(overflow2), .ovf_clr(ovf_clr2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes collect in a list; a word leaves when 4 are held or
    // after TIMEOUT idle cycles; the output FIFO is a plain queue.
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] a;
    } word_t;

    word_t       q[$];
    logic [7:0]  pend[$];
    int          idle = 0;
    logic [31:0] nxt  = 32'h0;
    bit          ovf  = 1'b0;
    bit          m_pop, m_flush, m_drop;
    word_t       m_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            pend.delete();
            idle = 0;
            nxt  = 32'h0;
            ovf  = 1'b0;
        end else begin
            m_pop   = (q.size() != 0) && mif.m_ready;
            m_flush = 1'b0;
            m_drop  = 1'b0;
            if (rx_done) begin
                pend.push_back(rx_data);
                idle    = 0;
                m_flush = (pend.size() == 4);
            end else if (pend.size() != 0) begin
                idle++;
                m_flush = (idle == c_TMO);
            end
            if (m_pop) void'(q.pop_front());
            if (m_flush) begin
                m_w = '0;
                foreach (pend[k]) begin
                    m_w.d = m_w.d | (32'(pend[k]) << (8 * k));
                    m_w.s = m_w.s | 4'(1 << k);
                end
                m_w.a = nxt;
                if (q.size() < c_DEPTH) begin
                    q.push_back(m_w);
                    nxt = nxt + 32'd4;
                end else begin
                    m_drop = 1'b1;
                    ovf    = 1'b1;
                end
                pend.delete();
                idle = 0;
            end
            if (ovf_clr && !m_drop) ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("m_valid", 32'(mif.m_valid), 32'(q.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(ovf));
        if (q.size() != 0) begin
            chk("m_data", mif.m_data, q[0].d);
            chk("m_strb", 32'(mif.m_strb), 32'(q[0].s));
            chk("m_addr", mif.m_addr, q[0].a);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge clk);
        rx2_data = b;
        rx2_done = 1'b1;
        @(negedge clk);
        rx2_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'h0; rx_done = 1'b0; ovf_clr = 1'b0;
        rx2_data = 8'h0; rx2_done = 1'b0; ovf_clr2 = 1'b0;
        mif.m_ready = 1'b1; mif2.m_ready = 1'b1;
        cyc(3);
        chk("rst_valid", 32'(mif.m_valid), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_data", mif.m_data, 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // full word, pulses 10 cycles apart
        send_byte(8'h11); cyc(8);
        send_byte(8'h22); cyc(8);
        send_byte(8'h33); cyc(8);
        send_byte(8'h44);
        chk("t1_valid", 32'(mif.m_valid), 32'h1);
        chk("t1_data", mif.m_data, 32'h44332211);
        chk("t1_strb", 32'(mif.m_strb), 32'hF);
        chk("t1_addr", mif.m_addr, 32'h0);
        cyc(3);

        // partial word flushed after 16 idle cycles
        send_byte(8'hAA);
        send_byte(8'hBB);
        cyc(15);
        chk("t2_early", 32'(mif.m_valid), 32'h0);
        cyc(1);
        chk("t2_valid", 32'(mif.m_valid), 32'h1);
        chk("t2_data", mif.m_data, 32'h0000BBAA);
        chk("t2_strb", 32'(mif.m_strb), 32'h3);
        chk("t2_addr", mif.m_addr, 32'h4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("t2_full_data", mif.m_data, 32'h04030201);
        chk("t2_full_addr", mif.m_addr, 32'h8);
        cyc(3);

        // byte landing on the timeout cycle suppresses the flush
        send_byte(8'h55);
        cyc(14);
        send_byte(8'h66);
        chk("t4_noflush", 32'(mif.m_valid), 32'h0);
        cyc(15);
        chk("t4_restart", 32'(mif.m_valid), 32'h0);
        cyc(1);
        chk("t4_data", mif.m_data, 32'h00006655);
        chk("t4_strb", 32'(mif.m_strb), 32'h3);
        chk("t4_addr", mif.m_addr, 32'hC);
        cyc(3);

        // overflow with the writer stalled
        mif.m_ready = 1'b0;
        for (int i = 0; i < 20; i++) send_byte(8'(8'h80 + i));
        chk("t3_count", 32'(fifo_count), 32'h4);
        chk("t3_ovf", 32'(overflow), 32'h1);
        chk("t3_head_addr", mif.m_addr, 32'h10);
        chk("t3_head_data", mif.m_data, 32'h83828180);
        mif.m_ready = 1'b1;
        cyc(4);
        chk("t3_drained", 32'(fifo_count), 32'h0);
        chk("t3_ovf_held", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'h0);
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        chk("t3_next_addr", mif.m_addr, 32'h20);
        cyc(3);

        // push into a full FIFO on the same edge as a pop
        mif.m_ready = 1'b0;
        for (int i = 0; i < 19; i++) send_byte(8'(8'h40 + i));
        chk("t5_full", 32'(fifo_count), 32'h4);
        @(negedge clk);
        rx_data = 8'h53; rx_done = 1'b1; mif.m_ready = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; mif.m_ready = 1'b0;
        chk("t5_count", 32'(fifo_count), 32'h4);
        chk("t5_ovf", 32'(overflow), 32'h0);
        chk("t5_head_addr", mif.m_addr, 32'h28);
        mif.m_ready = 1'b1;
        cyc(6);

        // asynchronous reset mid-operation
        mif.m_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
        chk("t6_pre_count", 32'(fifo_count), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(mif.m_valid), 32'h0);
        chk("t6_count", 32'(fifo_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mif.m_ready = 1'b1;
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        chk("t6_data", mif.m_data, 32'hA4A3A2A1);
        chk("t6_addr", mif.m_addr, 32'h0);
        cyc(3);

        // narrow address wraps modulo 16
        send2(8'h01); send2(8'h02); send2(8'h03); send2(8'h04);
        chk("t7_valid0", 32'(mif2.m_valid), 32'h1);
        chk("t7_addr0", 32'(mif2.m_addr), 32'hC);
        chk("t7_data0", mif2.m_data, 32'h04030201);
        send2(8'h05); send2(8'h06); send2(8'h07); send2(8'h08);
        chk("t7_addr1", 32'(mif2.m_addr), 32'h0);
        chk("t7_data1", mif2.m_data, 32'h08070605);
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
